reg_scoreboard: RTL and testbench

- Register-hazard controller between the decode stage and the register file read port.
- Tracks outstanding writes per architectural register with saturating lock counters.
- Serialises decode-stage operand reads onto the single register file read port.
- Stalls a read while its register is locked and completes it from the write-back bus the moment the final pending write retires (bypass).

---
 rtl/reg_scoreboard_if.sv | 33 +++
 rtl/reg_scoreboard.sv | 130 +++++++++++++
 tb/tb_reg_scoreboard.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// Decode-side read/lock/write-back bus and register file read port of the
// register-hazard scoreboard.
interface reg_scoreboard_if #(
  parameter int REG_SZ = 32
);
  logic              rd_req;
  logic [4:0]        rd_idx;
  logic              rd_flush;
  logic              rd_ack;
  logic [REG_SZ-1:0] rd_val;
  logic              lock_req;
  logic [4:0]        lock_idx;
  logic              lock_gnt;
  logic              wb_e;
  logic [4:0]        wb_idx;
  logic [REG_SZ-1:0] wb_val;
  logic              rf_re;
  logic [4:0]        rf_idx;
  logic              rf_rack;
  logic [REG_SZ-1:0] rf_in;

  modport master (
    output rd_req, rd_idx, rd_flush, lock_req, lock_idx,
           wb_e, wb_idx, wb_val, rf_rack, rf_in,
    input  rd_ack, rd_val, lock_gnt, rf_re, rf_idx
  );

  modport slave (
    input  rd_req, rd_idx, rd_flush, lock_req, lock_idx,
           wb_e, wb_idx, wb_val, rf_rack, rf_in,
    output rd_ack, rd_val, lock_gnt, rf_re, rf_idx
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: per-register lock counters plus a read FSM that
// serialises operand reads onto the register file and bypasses from write-back.
//   state   | meaning
//   IDLE    | no read in progress, sampling rd_req
//   RF_RD   | register file read issued, waiting for rf_rack
//   WAIT    | register locked, waiting for its last pending write-back
//   ACK     | rd_ack pulse, rd_val valid
module reg_scoreboard #(
  parameter int REG_SZ = 32,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  reg_scoreboard_if.slave   sb,
  output logic              busy,
  output logic [31:0]       locked,
  output logic [PERF_W-1:0] stall_cnt
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RF_RD = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]  cnt [32];
  logic [1:0]        state;
  logic [4:0]        cur_idx;
  logic [REG_SZ-1:0] rd_val_q;
  logic              rf_re_q;
  logic [4:0]        rf_idx_q;
  logic              lock_inc;
  logic              wb_dec;
  logic [31:0]       inc_vec;
  logic [31:0]       dec_vec;
  logic              bypass_now;
  logic              wait_hit;

  // A full counter still grants when the same register retires this cycle.
  assign sb.lock_gnt = (sb.lock_idx == 5'd0) || (cnt[sb.lock_idx] < CNT_MAX) ||
                       (sb.wb_e && (sb.wb_idx == sb.lock_idx));

  assign lock_inc = sb.lock_req && sb.lock_gnt && (sb.lock_idx != 5'd0);
  assign wb_dec   = sb.wb_e && (sb.wb_idx != 5'd0) && (cnt[sb.wb_idx] != '0);
  assign inc_vec  = lock_inc ? (32'd1 << sb.lock_idx) : 32'd0;
  assign dec_vec  = wb_dec   ? (32'd1 << sb.wb_idx)   : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        case ({inc_vec[i], dec_vec[i]})
          2'b10:   cnt[i] <= cnt[i] + CNT_ONE;
          2'b01:   cnt[i] <= cnt[i] - CNT_ONE;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  always_comb begin
    locked = '0;
    for (int i = 0; i < 32; i++) locked[i] = (cnt[i] != '0);
  end

  assign bypass_now = sb.wb_e && (sb.wb_idx == sb.rd_idx) && (cnt[sb.rd_idx] == CNT_ONE);
  assign wait_hit   = sb.wb_e && (sb.wb_idx == cur_idx) && (cnt[cur_idx] == CNT_ONE);

  // rd_flush takes priority over a completion arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_idx   <= '0;
      rd_val_q  <= '0;
      rf_re_q   <= 1'b0;
      rf_idx_q  <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sb.rd_req) begin
            cur_idx <= sb.rd_idx;
            if (sb.rd_idx == 5'd0) begin
              rd_val_q <= '0;
              state    <= S_ACK;
            end else if (bypass_now) begin
              rd_val_q <= sb.wb_val;
              state    <= S_ACK;
            end else if (cnt[sb.rd_idx] == '0) begin
              rf_re_q  <= 1'b1;
              rf_idx_q <= sb.rd_idx;
              state    <= S_RF_RD;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_RF_RD: begin
          if (sb.rd_flush) begin
            rf_re_q <= 1'b0;
            state   <= S_IDLE;
          end else if (sb.rf_rack) begin
            rd_val_q <= sb.rf_in;
            rf_re_q  <= 1'b0;
            state    <= S_ACK;
          end
        end
        S_WAIT: begin
          if (stall_cnt != {PERF_W{1'b1}}) stall_cnt <= stall_cnt + PERF_W'(1);
          if (sb.rd_flush) begin
            state <= S_IDLE;
          end else if (wait_hit) begin
            rd_val_q <= sb.wb_val;
            state    <= S_ACK;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign sb.rd_ack = (state == S_ACK);
  assign sb.rd_val = rd_val_q;
  assign sb.rf_re  = rf_re_q;
  assign sb.rf_idx = rf_idx_q;
  assign busy      = (state != S_IDLE);
endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed hazard scenarios, then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_reg_scoreboard;
  localparam int REG_SZ = 32;
  localparam int RD_NONE = 0, RD_FROM_RF = 1, RD_STALLED = 2, RD_DONE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [31:0] locked;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  reg_scoreboard_if #(.REG_SZ(REG_SZ)) sb ();

  reg_scoreboard #(.REG_SZ(REG_SZ), .CNT_W(2), .PERF_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .sb        (sb),
    .busy      (busy),
    .locked    (locked),
    .stall_cnt (stall_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference model: outstanding-write counts and the fate of the current read.
  int          m_cnt [32];
  int          m_rd;
  int          m_widx;
  logic [31:0] m_val;
  logic [4:0]  m_rfidx;
  int          m_stall;

  function automatic logic model_gnt();
    return (sb.lock_idx == 5'd0) || (m_cnt[sb.lock_idx] < 3) ||
           (sb.wb_e && (sb.wb_idx == sb.lock_idx));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_rd = RD_NONE; m_widx = 0; m_val = '0; m_rfidx = '0; m_stall = 0;
  endtask

  task automatic model_edge();
    int li, wi, ri;
    bit do_inc, do_dec;
    li = int'(sb.lock_idx); wi = int'(sb.wb_idx); ri = int'(sb.rd_idx);
    do_inc = sb.lock_req && model_gnt() && (li != 0);
    do_dec = sb.wb_e && (wi != 0) && (m_cnt[wi] > 0);
    case (m_rd)
      RD_NONE: if (sb.rd_req) begin
        if (ri == 0) begin m_val = '0; m_rd = RD_DONE; end
        else if (sb.wb_e && wi == ri && m_cnt[ri] == 1) begin m_val = sb.wb_val; m_rd = RD_DONE; end
        else if (m_cnt[ri] == 0) begin m_rfidx = sb.rd_idx; m_rd = RD_FROM_RF; end
        else begin m_widx = ri; m_rd = RD_STALLED; end
      end
      RD_FROM_RF: begin
        if (sb.rd_flush) m_rd = RD_NONE;
        else if (sb.rf_rack) begin m_val = sb.rf_in; m_rd = RD_DONE; end
      end
      RD_STALLED: begin
        if (m_stall < 65535) m_stall++;
        if (sb.rd_flush) m_rd = RD_NONE;
        else if (sb.wb_e && wi == m_widx && m_cnt[m_widx] == 1) begin m_val = sb.wb_val; m_rd = RD_DONE; end
      end
      default: m_rd = RD_NONE;
    endcase
    if (do_inc) m_cnt[li]++;
    if (do_dec) m_cnt[wi]--;
  endtask

  task automatic check_outputs();
    logic [31:0] m_locked;
    for (int i = 0; i < 32; i++) m_locked[i] = (m_cnt[i] != 0);
    check("rd_ack",    sb.rd_ack, m_rd == RD_DONE);
    check("busy",      busy,      m_rd != RD_NONE);
    check("rf_re",     sb.rf_re,  m_rd == RD_FROM_RF);
    check("rf_idx",    sb.rf_idx, m_rfidx);
    check("rd_val",    sb.rd_val, m_val);
    check("locked",    locked,    m_locked);
    check("stall_cnt", stall_cnt, m_stall);
  endtask

  task automatic tick();
    #1;
    check("lock_gnt", sb.lock_gnt, model_gnt());
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    sb.rd_req = 0; sb.rd_idx = '0; sb.rd_flush = 0;
    sb.lock_req = 0; sb.lock_idx = '0;
    sb.wb_e = 0; sb.wb_idx = '0; sb.wb_val = '0;
    sb.rf_rack = 0; sb.rf_in = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    tick();

    // unlocked read through the register file
    sb.rd_req = 1; sb.rd_idx = 5'd5;
    tick();
    check("t1_rf_re", sb.rf_re, 1);
    check("t1_rf_idx", sb.rf_idx, 5);
    tick(); tick();
    sb.rf_rack = 1; sb.rf_in = 32'h1234;
    tick();
    check("t1_ack", sb.rd_ack, 1);
    check("t1_val", sb.rd_val, 32'h1234);
    check("t1_rf_re_low", sb.rf_re, 0);
    idle_inputs();
    tick();
    check("t1_ack_once", sb.rd_ack, 0);

    // locked read completes from write-back
    sb.lock_req = 1; sb.lock_idx = 5'd7;
    tick();
    idle_inputs();
    sb.rd_req = 1; sb.rd_idx = 5'd7;
    tick();
    check("t2_busy", busy, 1);
    check("t2_rf_re", sb.rf_re, 0);
    repeat (3) tick();
    check("t2_no_ack", sb.rd_ack, 0);
    sb.wb_e = 1; sb.wb_idx = 5'd7; sb.wb_val = 32'hDEAD;
    tick();
    check("t2_ack", sb.rd_ack, 1);
    check("t2_val", sb.rd_val, 32'hDEAD);
    check("t2_stall", stall_cnt, 4);
    check("t2_unlocked", locked[7], 0);
    idle_inputs();
    tick();

    // counter saturation and lock-with-retire
    sb.lock_req = 1; sb.lock_idx = 5'd9;
    for (int k = 0; k < 3; k++) begin
      #1 check("t3_gnt", sb.lock_gnt, 1);
      tick();
    end
    #1 check("t3_gnt_full", sb.lock_gnt, 0);
    tick();
    sb.wb_e = 1; sb.wb_idx = 5'd9; sb.wb_val = 32'h1;
    #1 check("t3_gnt_retire", sb.lock_gnt, 1);
    tick();
    sb.lock_req = 0;
    tick();
    check("t3_cnt2", locked[9], 1);
    tick();
    check("t3_cnt1", locked[9], 1);
    tick();
    check("t3_cnt0", locked[9], 0);
    idle_inputs();

    // register zero
    sb.rd_req = 1; sb.rd_idx = 5'd0; sb.lock_req = 1; sb.lock_idx = 5'd0;
    #1 check("t4_gnt", sb.lock_gnt, 1);
    tick();
    check("t4_ack", sb.rd_ack, 1);
    check("t4_val", sb.rd_val, 0);
    check("t4_locked0", locked[0], 0);
    check("t4_rf_re", sb.rf_re, 0);
    idle_inputs();
    tick();

    // 2 -> 1 retire keeps waiting
    sb.lock_req = 1; sb.lock_idx = 5'd3;
    tick(); tick();
    idle_inputs();
    sb.rd_req = 1; sb.rd_idx = 5'd3;
    tick();
    sb.wb_e = 1; sb.wb_idx = 5'd3; sb.wb_val = 32'd1;
    tick();
    check("t5_still_wait", busy, 1);
    check("t5_no_ack", sb.rd_ack, 0);
    sb.wb_val = 32'd2;
    tick();
    check("t5_ack", sb.rd_ack, 1);
    check("t5_val", sb.rd_val, 2);
    idle_inputs();
    tick();

    // flush while stalled
    sb.lock_req = 1; sb.lock_idx = 5'd4;
    tick();
    idle_inputs();
    sb.rd_req = 1; sb.rd_idx = 5'd4;
    tick(); tick();
    sb.rd_req = 0; sb.rd_flush = 1;
    tick();
    check("t6_idle", busy, 0);
    check("t6_no_ack", sb.rd_ack, 0);
    idle_inputs();
    sb.wb_e = 1; sb.wb_idx = 5'd4;
    tick();
    check("t6_no_ack2", sb.rd_ack, 0);
    idle_inputs();

    // async reset during a register file read
    sb.rd_req = 1; sb.rd_idx = 5'd6;
    tick();
    check("t7_rf_re", sb.rf_re, 1);
    #2 rst = 1'b1;
    #1;
    check("t7_async_rf_re", sb.rf_re, 0);
    check("t7_async_busy", busy, 0);
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
    check_outputs();

    // random traffic on a few registers to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      sb.lock_req = ($urandom % 4) == 0;
      sb.lock_idx = 5'($urandom % 8);
      sb.wb_e     = ($urandom % 3) == 0;
      sb.wb_idx   = 5'($urandom % 8);
      sb.wb_val   = $urandom;
      sb.rf_in    = $urandom;
      sb.rf_rack  = ($urandom % 3) == 0;
      sb.rd_flush = 0;
      if (m_rd == RD_DONE) begin
        sb.rd_req   = 0;
        sb.rd_flush = ($urandom % 8) == 0;
      end else if (m_rd == RD_NONE) begin
        if (!sb.rd_req && ($urandom % 2) == 1) begin
          sb.rd_req = 1;
          sb.rd_idx = 5'($urandom % 8);
        end
        sb.rd_flush = ($urandom % 16) == 0;
      end else if (($urandom % 24) == 0) begin
        sb.rd_flush = 1;
        sb.rd_req   = 0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
